// File: rtl/cpu_regbank_wb.sv
// rtl/cpu_regbank_wb.sv - MCS8 architectural register bank with W-stage writeback commit
// Seven 8-bit registers (A,B,C,D,E,H,L); index 7 (M) is the memory path and never stored.
module cpu_regbank_wb #(
   parameter int CNT_W = 16
) (
   input  logic             CLK_I,
   input  logic             RSTN_I,
   input  logic [2:0]       W_DST_I,
   input  logic             W_VALID_I,
   input  logic             W_DSTR_CS_I,
   input  logic             W_DSTR_CS_C_I,
   input  logic             W_DSTR_CS_S_I,
   input  logic             W_DSTR_CS_E_I,
   input  logic             W_DSTR_CS_M_I,
   input  logic [7:0]       W_VAL_C_I,
   input  logic [7:0]       W_VAL_S_I,
   input  logic [7:0]       W_VAL_E_I,
   input  logic [7:0]       W_VAL_M_I,
   input  logic [2:0]       RD_SRC_A_I,
   input  logic [2:0]       RD_SRC_B_I,
   output logic [7:0]       REG_BANK_A_O,
   output logic [7:0]       REG_BANK_B_O,
   output logic [13:0]      HL_ADDR_O,
   output logic             WB_ACK_O,
   output logic             WR_ERR_O,
   input  logic             ERR_CLR_I,
   output logic [CNT_W-1:0] WB_CNT_O
);

   logic             req;
   logic             legal;
   logic             commit;
   logic [3:0]       sel;
   logic [7:0]       wdata;
   logic [7:0]       bank_q [7];
   logic [7:0]       bank_d [7];
   logic             ack_q;
   logic             ack_d;
   logic             err_q;
   logic             err_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign req    = W_VALID_I & W_DSTR_CS_I;
   assign sel    = {W_DSTR_CS_C_I, W_DSTR_CS_S_I, W_DSTR_CS_E_I, W_DSTR_CS_M_I};
   // Exactly one strobe: nonzero, and clearing the lowest set bit leaves nothing.
   assign legal  = (sel != 4'b0000) && ((sel & (sel - 4'd1)) == 4'b0000);
   assign commit = req & legal & (W_DST_I != 3'd7);

   assign wdata = ({8{sel[3]}} & W_VAL_C_I) | ({8{sel[2]}} & W_VAL_S_I) |
                  ({8{sel[1]}} & W_VAL_E_I) | ({8{sel[0]}} & W_VAL_M_I);

   always_comb begin
      for (int i = 0; i < 7; i++) begin
         bank_d[i] = bank_q[i];
         if (commit && (W_DST_I == 3'(i))) begin
            bank_d[i] = wdata;
         end
      end
      ack_d = commit;
      err_d = err_q;
      if (ERR_CLR_I) begin
         err_d = 1'b0;
      end
      if (req && !legal) begin
         err_d = 1'b1;
      end
      cnt_d = commit ? (cnt_q + {{(CNT_W-1){1'b0}}, 1'b1}) : cnt_q;
   end

   always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) begin
         for (int i = 0; i < 7; i++) begin
            bank_q[i] <= 8'h00;
         end
         ack_q <= 1'b0;
         err_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         bank_q <= bank_d;
         ack_q  <= ack_d;
         err_q  <= err_d;
         cnt_q  <= cnt_d;
      end
   end

   // No write-to-read bypass: forwarding of in-flight W results happens downstream.
   always_comb begin
      REG_BANK_A_O = 8'h00;
      REG_BANK_B_O = 8'h00;
      for (int i = 0; i < 7; i++) begin
         if (RD_SRC_A_I == 3'(i)) begin
            REG_BANK_A_O = bank_q[i];
         end
         if (RD_SRC_B_I == 3'(i)) begin
            REG_BANK_B_O = bank_q[i];
         end
      end
   end

   assign HL_ADDR_O = {bank_q[5][5:0], bank_q[6]};
   assign WB_ACK_O  = ack_q;
   assign WR_ERR_O  = err_q;
   assign WB_CNT_O  = cnt_q;

endmodule

// File: tb/tb_cpu_regbank_wb.sv
// tb/tb_cpu_regbank_wb.sv - self-checking bench for cpu_regbank_wb against a behavioural model
module tb_cpu_regbank_wb;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [2:0]  w_dst = '0;
   logic        w_valid = 1'b0;
   logic        w_cs = 1'b0;
   logic        cs_c = 1'b0, cs_s = 1'b0, cs_e = 1'b0, cs_m = 1'b0;
   logic [7:0]  val_c = '0, val_s = '0, val_e = '0, val_m = '0;
   logic [2:0]  rd_a = '0, rd_b = '0;
   logic        err_clr = 1'b0;

   logic [7:0]  bank_a, bank_b, bank_a4, bank_b4;
   logic [13:0] hl_addr, hl_addr4;
   logic        ack, err, ack4, err4;
   logic [15:0] cnt;
   logic [3:0]  cnt4;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_regs [8];
   logic       m_ack;
   logic       m_err;
   int         m_cnt;

   always #10 clk = ~clk;

   cpu_regbank_wb #(.CNT_W(16)) dut (
      .CLK_I(clk), .RSTN_I(rstn), .W_DST_I(w_dst), .W_VALID_I(w_valid), .W_DSTR_CS_I(w_cs),
      .W_DSTR_CS_C_I(cs_c), .W_DSTR_CS_S_I(cs_s), .W_DSTR_CS_E_I(cs_e), .W_DSTR_CS_M_I(cs_m),
      .W_VAL_C_I(val_c), .W_VAL_S_I(val_s), .W_VAL_E_I(val_e), .W_VAL_M_I(val_m),
      .RD_SRC_A_I(rd_a), .RD_SRC_B_I(rd_b), .REG_BANK_A_O(bank_a), .REG_BANK_B_O(bank_b),
      .HL_ADDR_O(hl_addr), .WB_ACK_O(ack), .WR_ERR_O(err), .ERR_CLR_I(err_clr), .WB_CNT_O(cnt)
   );

   cpu_regbank_wb #(.CNT_W(4)) dut4 (
      .CLK_I(clk), .RSTN_I(rstn), .W_DST_I(w_dst), .W_VALID_I(w_valid), .W_DSTR_CS_I(w_cs),
      .W_DSTR_CS_C_I(cs_c), .W_DSTR_CS_S_I(cs_s), .W_DSTR_CS_E_I(cs_e), .W_DSTR_CS_M_I(cs_m),
      .W_VAL_C_I(val_c), .W_VAL_S_I(val_s), .W_VAL_E_I(val_e), .W_VAL_M_I(val_m),
      .RD_SRC_A_I(rd_a), .RD_SRC_B_I(rd_b), .REG_BANK_A_O(bank_a4), .REG_BANK_B_O(bank_b4),
      .HL_ADDR_O(hl_addr4), .WB_ACK_O(ack4), .WR_ERR_O(err4), .ERR_CLR_I(err_clr), .WB_CNT_O(cnt4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      m_ack = 1'b0;
      m_err = 1'b0;
      m_cnt = 0;
   endtask

   // Model of one clock edge from the currently driven inputs.
   task automatic model_edge();
      int n;
      logic [7:0] d;
      bit req;
      n   = int'(cs_c) + int'(cs_s) + int'(cs_e) + int'(cs_m);
      req = w_valid && w_cs;
      d   = cs_c ? val_c : cs_s ? val_s : cs_e ? val_e : val_m;
      m_ack = 1'b0;
      if (req && n == 1 && w_dst != 3'd7) begin
         m_regs[w_dst] = d;
         m_ack = 1'b1;
         m_cnt = m_cnt + 1;
      end
      if (req && n != 1) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
   endtask

   task automatic check_state(input string tag);
      for (int i = 0; i < 8; i++) begin
         rd_a = 3'(i);
         rd_b = 3'(7 - i);
         #1;
         chk({tag, "_rdA"}, {24'h0, bank_a}, {24'h0, m_regs[i]});
         chk({tag, "_rdB"}, {24'h0, bank_b}, {24'h0, m_regs[7 - i]});
         chk({tag, "_rdA4"}, {24'h0, bank_a4}, {24'h0, m_regs[i]});
      end
      chk({tag, "_hl"}, {18'h0, hl_addr}, {18'h0, m_regs[5][5:0], m_regs[6]});
      chk({tag, "_ack"}, {31'h0, ack}, {31'h0, m_ack});
      chk({tag, "_err"}, {31'h0, err}, {31'h0, m_err});
      chk({tag, "_cnt"}, {16'h0, cnt}, 32'(m_cnt % 65536));
      chk({tag, "_ack4"}, {31'h0, ack4}, {31'h0, m_ack});
      chk({tag, "_err4"}, {31'h0, err4}, {31'h0, m_err});
      chk({tag, "_cnt4"}, {28'h0, cnt4}, 32'(m_cnt % 16));
   endtask

   // Drive one W-stage cycle, check the pre-edge (old) read value, clock, then check all state.
   task automatic cycle(input string tag, input logic v, input logic cs, input logic [3:0] strb,
                        input logic [2:0] dst, input logic [7:0] vc, input logic [7:0] vs,
                        input logic [7:0] ve, input logic [7:0] vm, input logic clr);
      w_valid = v; w_cs = cs;
      {cs_c, cs_s, cs_e, cs_m} = strb;
      w_dst = dst; val_c = vc; val_s = vs; val_e = ve; val_m = vm; err_clr = clr;
      rd_a = dst; rd_b = dst;
      #1;
      chk({tag, "_pre"}, {24'h0, bank_a}, {24'h0, m_regs[dst]});
      chk({tag, "_preB"}, {24'h0, bank_b}, {24'h0, m_regs[dst]});
      @(posedge clk);
      model_edge();
      #1;
      check_state(tag);
   endtask

   task automatic idle(input string tag);
      cycle(tag, 1'b0, 1'b0, 4'b0000, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
   endtask

   initial begin
      logic [3:0] strb;
      model_reset();
      repeat (2) @(posedge clk);
      #5;
      check_state("reset_low");
      rstn = 1'b1;
      #1;
      check_state("reset_rel");

      cycle("commitC", 1, 1, 4'b1000, 3'd1, 8'h5A, 8'h11, 8'h22, 8'h33, 0);
      idle("commitC_idle");

      cycle("writeH", 1, 1, 4'b0100, 3'd5, 8'h00, 8'hFF, 8'h00, 8'h00, 0);
      cycle("writeL", 1, 1, 4'b0010, 3'd6, 8'h00, 8'h00, 8'h34, 8'h00, 0);
      chk("hl_3F34", {18'h0, hl_addr}, 32'h3F34);
      cycle("dstM", 1, 1, 4'b0001, 3'd7, 8'h00, 8'h00, 8'h00, 8'h99, 0);

      cycle("illegal", 1, 1, 4'b1001, 3'd2, 8'hAA, 8'h00, 8'h00, 8'hBB, 0);
      idle("err_sticky");
      cycle("clr_vs_set", 1, 1, 4'b0000, 3'd3, 8'h00, 8'h00, 8'h00, 8'h00, 1);
      cycle("clr_alone", 0, 0, 4'b0000, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1);
      cycle("noreq_2strb", 0, 1, 4'b1100, 3'd2, 8'h77, 8'h66, 8'h00, 8'h00, 0);
      cycle("cs0_2strb", 1, 0, 4'b0011, 3'd2, 8'h00, 8'h00, 8'h55, 8'h44, 0);

      cycle("b2b_1", 1, 1, 4'b1000, 3'd0, 8'h01, 8'h00, 8'h00, 8'h00, 0);
      cycle("b2b_2", 1, 1, 4'b0100, 3'd0, 8'h00, 8'h02, 8'h00, 8'h00, 0);
      cycle("b2b_3", 1, 1, 4'b0001, 3'd0, 8'h00, 8'h00, 8'h00, 8'h03, 0);
      idle("b2b_idle");

      // Reset asserted between edges while a commit is being presented.
      w_valid = 1; w_cs = 1; {cs_c, cs_s, cs_e, cs_m} = 4'b1000; w_dst = 3'd4; val_c = 8'hC3;
      err_clr = 0;
      @(posedge clk);
      model_edge();
      #4;
      rstn = 1'b0;
      model_reset();
      #1;
      chk("async_ack", {31'h0, ack}, 32'h0);
      chk("async_cnt", {16'h0, cnt}, 32'h0);
      check_state("async_rst");
      @(posedge clk);
      #5;
      rstn = 1'b1;
      #1;
      check_state("async_rel");

      // Sixteen commits wrap the 4-bit counter back to zero with ack still high.
      for (int k = 0; k < 16; k++) begin
         cycle("wrap", 1, 1, 4'b0010, 3'(k % 7), 8'h00, 8'h00, 8'(k * 13), 8'h00, 0);
      end
      chk("wrap_cnt4_zero", {28'h0, cnt4}, 32'h0);
      chk("wrap_ack4", {31'h0, ack4}, 32'h1);
      idle("wrap_idle");

      for (int k = 0; k < 200; k++) begin
         if ($urandom_range(0, 9) < 7) strb = 4'b0001 << $urandom_range(0, 3);
         else strb = 4'($urandom_range(0, 15));
         cycle("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), strb,
               3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 8'($urandom),
               8'($urandom), 1'($urandom_range(0, 5) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
